// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the shared instruction/data port.
// Accepts one word request at a time, waits LATENCY cycles, then commits the
// write or returns registered read data along with a one-cycle MemReady pulse.
//
// Parameters:
//   DEPTH_LOG2 - log2 of storage depth in 32-bit words
//   LATENCY    - wait cycles from acceptance to response (1..15)
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   MemReq     - request valid, held until MemReady
//   MemWrite   - 1 = write, 0 = read, sampled with MemReq
//   Adr        - word-aligned byte address
//   WriteData  - store data, sampled with MemReq
//   ReadData   - registered read data, valid while MemReady=1 for a read
//   MemReady   - one-cycle response pulse
//   AdrErr     - request was rejected (misaligned or out of range)
module mem_responder #(
   parameter int unsigned DEPTH_LOG2 = 6,
   parameter int unsigned LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReq,
   input  logic        MemWrite,
   input  logic [31:0] Adr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        MemReady,
   output logic        AdrErr
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam int unsigned AW    = DEPTH_LOG2 + 2;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    we_q, we_d;
   logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
   logic [31:0]             wdata_q, wdata_d;
   logic                    err_q, err_d;
   logic                    rdy_q, rdy_d;
   logic                    aerr_q, aerr_d;
   logic [31:0]             rdata_q, rdata_d;
   logic                    mem_we_c;
   logic                    adr_err_c;

   // Storage has no reset; contents undefined until written.
   logic [31:0] mem_q [DEPTH];

   // Reject misaligned addresses and anything beyond the array (no aliasing).
   assign adr_err_c = (Adr[1:0] != 2'b00) || ((Adr >> AW) != 32'd0);

   // State and request registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b0;
         aerr_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdy_q   <= rdy_d;
         aerr_q  <= aerr_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state logic; the access and the response flags are produced on the
   // BUSY->RESP edge so MemReady/AdrErr/ReadData are all registered in RESP.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      rdy_d    = 1'b0;
      aerr_d   = 1'b0;
      rdata_d  = rdata_q;
      mem_we_c = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (MemReq) begin
               state_d = S_BUSY;
               cnt_d   = CNT_W'(LATENCY - 1);
               we_d    = MemWrite;
               idx_d   = Adr[AW-1:2];
               wdata_d = WriteData;
               err_d   = adr_err_c;
            end
         end
         S_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = S_RESP;
               rdy_d   = 1'b1;
               aerr_d  = err_q;
               if (err_q) begin
                  rdata_d = '0;
               end else if (we_q) begin
                  mem_we_c = 1'b1;
               end else begin
                  rdata_d = mem_q[idx_q];
               end
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Array write port; gated by state so a reset before the commit edge drops the write.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign ReadData = rdata_q;
   assign MemReady = rdy_q;
   assign AdrErr   = aerr_q;

endmodule
